imem_fetch: RTL

Parametrised byte-addressed instruction memory for the RV32I datapath. Returns little-endian 32-bit words over a valid/ready request/response handshake. Adds the following to the fetch path:
- Misalignment and out-of-range fault reporting.
- A byte-wide load port for program loading.
- Output backpressure.
- A fetch counter.

Sits between the PC/fetch stage and the decode stage.

---
 rtl/imem_fetch_if.sv | 12 +
 rtl/imem_fetch.sv | 70 +++++++
 2 files changed

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response handshake between the PC stage and imem_fetch.
interface imem_fetch_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_fault;
    modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_fault);
    modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_fault);
endinterface

// File: rtl/imem_fetch.sv
// imem_fetch: byte-addressed instruction memory returning little-endian words over valid/ready, with fault reporting, byte loader and fetch counter.
module imem_fetch #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 32,
    parameter int INIT_COUNT = 16,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_if.slave       bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [CNT_W-1:0]  fetch_count
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [DEPTH-1:0][7:0] mem_t;

    function automatic mem_t preload();
        mem_t m = '0;
        for (int i = 0; i < INIT_COUNT && i < DEPTH; i++) m[i] = 8'(i + 1);
        return m;
    endfunction

    // Preload is the only source of initial contents; reset leaves memory untouched.
    mem_t             mem_q = preload();
    mem_t             mem_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_fault_q, rsp_fault_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic [1:0]       fault;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word;

    always_comb begin
        bus.req_ready = (!rsp_valid_q || bus.rsp_ready) && !ld_en && !rst;
        accept = bus.req_valid && bus.req_ready;
        idx = bus.req_addr[AW-1:0];
        fault = {bus.req_addr > ADDR_W'(DEPTH - 4), bus.req_addr[1:0] != 2'b00};
        rd_word = {mem_q[idx + AW'(3)], mem_q[idx + AW'(2)], mem_q[idx + AW'(1)], mem_q[idx]};
        rsp_valid_d = accept || (rsp_valid_q && !bus.rsp_ready);
        rsp_data_d = accept ? (fault != 2'b00 ? 32'h0 : rd_word) : rsp_data_q;
        rsp_fault_d = accept ? fault : rsp_fault_q;
        count_d = (accept && count_q != '1) ? count_q + CNT_W'(1) : count_q;
        mem_d = mem_q;
        if (ld_en && !rst && ld_addr < ADDR_W'(DEPTH)) mem_d[ld_addr[AW-1:0]] = ld_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= '0;
            count_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            count_q     <= count_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign fetch_count   = count_q;
endmodule
